// File: rtl/rv_pkg.sv
// Shared RV32I constants and branch-history counter helpers for the fetch slice.
`timescale 1ns/1ps
package rv_pkg;

    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_cnt_t;

    // Saturating 2-bit counter step: never wraps past ST or SNT.
    function automatic bht_cnt_t bht_next(input bht_cnt_t cur, input logic taken);
        bht_cnt_t nxt;
        case (cur)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            ST:      nxt = taken ? ST  : WT;
            default: nxt = WNT;
        endcase
        return nxt;
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/branch_predictor_bht.sv
// Table of 2-bit saturating counters: combinational read, synchronous training.
`timescale 1ns/1ps
module branch_predictor_bht #(
    parameter int IDX_W = 6
) (
    input  logic             stg_clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);
    import rv_pkg::*;

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0] cnt_r [ENTRIES];

    // Counter array: weakly not-taken after reset, trained by execute.
    always_ff @(posedge stg_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_r[i] <= WNT;
            end
        end else if (upd_valid) begin
            cnt_r[upd_idx] <= bht_next(bht_cnt_t'(cnt_r[upd_idx]), upd_taken);
        end
    end

    // Read sees the pre-update value when the same entry trains this cycle.
    assign rd_taken = cnt_r[rd_idx][1];

endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: PC, B/JAL pre-decode, BHT prediction, redirect/flush.
`timescale 1ns/1ps
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BHT_IDX_W = 6,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        stg_clk,
    input  logic        reset,
    input  logic        stg_ena,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        branch_prediction_out,
    output logic        valid_out
);
    import rv_pkg::*;

    logic [31:0] pc_r;
    logic [31:0] pc_out_r;
    logic [31:0] instr_out_r;
    logic        pred_out_r;
    logic        valid_out_r;

    logic        is_br_s;
    logic        is_jal_s;
    logic        bht_taken_s;
    logic        pred_taken_s;
    logic [31:0] next_pc_s;
    logic        unused_upd_pc_s;

    assign unused_upd_pc_s = ^{upd_pc[31:BHT_IDX_W+2], upd_pc[1:0]};

    branch_predictor_bht #(
        .IDX_W(BHT_IDX_W)
    ) u_bht (
        .stg_clk  (stg_clk),
        .reset    (reset),
        .rd_idx   (pc_r[BHT_IDX_W+1:2]),
        .rd_taken (bht_taken_s),
        .upd_valid(upd_valid),
        .upd_idx  (upd_pc[BHT_IDX_W+1:2]),
        .upd_taken(upd_taken)
    );

    // Pre-decode and next-PC selection; JALR and everything else fall through to PC+4.
    always_comb begin
        is_br_s      = 1'b0;
        is_jal_s     = 1'b0;
        pred_taken_s = 1'b0;
        next_pc_s    = pc_r + 32'd4;
        is_br_s      = (imem_data[6:0] == OP_BRANCH);
        is_jal_s     = (imem_data[6:0] == OP_JAL);
        pred_taken_s = is_jal_s | (is_br_s & bht_taken_s);
        if (pred_taken_s) begin
            next_pc_s = pc_r + (is_jal_s ? imm_j(imem_data) : imm_b(imem_data));
        end else begin
            next_pc_s = pc_r + 32'd4;
        end
    end

    // PC and IF/ID register; redirect overrides a stall.
    always_ff @(posedge stg_clk or negedge reset) begin
        if (!reset) begin
            pc_r        <= RESET_PC;
            pc_out_r    <= 32'h0000_0000;
            instr_out_r <= NOP_INSTR;
            pred_out_r  <= 1'b0;
            valid_out_r <= 1'b0;
        end else if (redirect_valid) begin
            pc_r        <= redirect_pc;
            instr_out_r <= NOP_INSTR;
            pred_out_r  <= 1'b0;
            valid_out_r <= 1'b0;
        end else if (stg_ena) begin
            pc_r        <= next_pc_s;
            pc_out_r    <= pc_r;
            instr_out_r <= imem_data;
            pred_out_r  <= pred_taken_s;
            valid_out_r <= 1'b1;
        end
    end

    assign imem_addr             = pc_r;
    assign pc_out                = pc_out_r;
    assign instr_out             = instr_out_r;
    assign branch_prediction_out = pred_out_r;
    assign valid_out             = valid_out_r;

endmodule
